// File: rtl/cpu_pkg.sv
// Shared accumulator-CPU definitions: instruction field positions, opcodes and fetch FSM states.
package cpu_pkg;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int FUNC_MSB = 5;
  localparam int IMM_MSB  = 7;

  localparam logic [3:0] OP_ALU  = 4'd15;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_ALUI = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd9;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t IDLE  = 2'd0;
  localparam fetch_state_t FETCH = 2'd1;
  localparam fetch_state_t ISSUE = 2'd2;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Fetch-side bus: instruction-memory req/ack port plus the issue valid/ready port to the decode controller.
interface instr_fetch_seq_if #(
  parameter int ADDR_W = 8
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic [3:0]        opcode;
  logic [5:0]        func;
  logic [7:0]        imm;
  logic              issue_valid;
  logic              issue_ready;
  logic              pc_flag;

  modport master (
    output imem_req, imem_addr, opcode, func, imm, issue_valid,
    input  imem_ack, imem_rdata, issue_ready, pc_flag
  );

  modport slave (
    input  imem_req, imem_addr, opcode, func, imm, issue_valid,
    output imem_ack, imem_rdata, issue_ready, pc_flag
  );

endinterface

// File: rtl/instr_fetch_seq_next_pc_calc.sv
// Next-PC selection for the fetch sequencer. FETCH_REL_BRANCH_EN selects PC-relative jumps
// (pc + 1 + sign-extended imm); otherwise jumps are absolute to the zero-extended imm.
module next_pc_calc #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        imm,
  input  logic              pc_flag,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jump_pc;

  assign seq_pc = pc + ADDR_W'(1);

`ifdef FETCH_REL_BRANCH_EN
  assign jump_pc = seq_pc + ADDR_W'(signed'(imm));
`else
  // Size cast zero-extends for wide PCs and truncates when ADDR_W < 8.
  assign jump_pc = ADDR_W'(imm);
`endif

  assign next_pc = pc_flag ? jump_pc : seq_pc;

endmodule

// File: rtl/instr_fetch_seq.sv
// Multi-cycle fetch/sequencer: owns the PC, reads instructions over req/ack and issues decoded fields
// over valid/ready. Jump mode is selected by FETCH_REL_BRANCH_EN inside next_pc_calc.
module instr_fetch_seq
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] pc,
  instr_fetch_seq_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_next;
  logic [3:0]        opcode_q, opcode_d;
  logic [5:0]        func_q, func_d;
  logic [7:0]        imm_q, imm_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              handshake;

  assign handshake = valid_q && bus.issue_ready;

  next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc      (pc_q),
    .imm     (imm_q),
    .pc_flag (bus.pc_flag),
    .next_pc (pc_next)
  );

  // run is only consulted in IDLE and at the issue handshake, so a started fetch always completes.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    func_d   = func_q;
    imm_d    = imm_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          opcode_d = bus.imem_rdata[OPC_MSB:OPC_LSB];
          func_d   = bus.imem_rdata[FUNC_MSB:0];
          imm_d    = bus.imem_rdata[IMM_MSB:0];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          pc_d    = pc_next;
          state_d = run ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d   = (state_d == FETCH);
    valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      opcode_q <= '0;
      func_q   <= '0;
      imm_q    <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      func_q   <= func_d;
      imm_q    <= imm_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
    end
  end

  assign pc              = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.imem_req    = req_q;
  assign bus.issue_valid = valid_q;
  assign bus.opcode      = opcode_q;
  assign bus.func        = func_q;
  assign bus.imm         = imm_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: directed programs push expected fetches/issues into queues,
// a memory/controller model answers the handshakes, and a monitor pops and compares.
module tb_instr_fetch_seq;
  import cpu_pkg::*;

  localparam int ADDR_W = 8;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] opc;
    logic [5:0] func;
    logic [7:0] imm;
  } exp_issue_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              run = 1'b0;
  logic [ADDR_W-1:0] pc;

  instr_fetch_seq_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_seq #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .pc    (pc),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         cycle = 0;
  int         hs_count = 0;
  int         last_hs = -1;
  int         req_cycles = 0;
  int         exp_req_cycles = 0;
  bit         check_gap = 1'b0;
  int         ack_delay = 0;
  int         ready_delay = 0;
  int         ack_wait = 0;
  int         ready_wait = 0;
  bit         hold_en = 1'b0;
  logic [7:0] hold_pc = 8'h00;

  logic [15:0] mem [256];
  bit          jump_map [256];
  exp_issue_t  issue_q [$];
  logic [7:0]  fetch_q [$];

  always @(posedge clk) cycle++;

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic exp_issue(input logic [7:0] p, input logic [3:0] o, input logic [5:0] f,
                           input logic [7:0] i);
    exp_issue_t e;
    e.pc = p; e.opc = o; e.func = f; e.imm = i;
    issue_q.push_back(e);
    fetch_q.push_back(p);
  endtask

  task automatic clear_program();
    for (int i = 0; i < 256; i++) begin
      mem[i]      = 16'h0000;
      jump_map[i] = 1'b0;
    end
  endtask

  // Instruction memory and decode controller model, driven away from the active edge.
  initial begin
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0000;
    bus.issue_ready = 1'b0;
    bus.pc_flag     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack_wait   = 0;
        ready_wait = 0;
      end
      if (bus.imem_req && ack_wait >= ack_delay) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem[bus.imem_addr];
        ack_wait       = 0;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = bus.imem_req ? 16'hDEAD : 16'hBEEF;
        ack_wait       = bus.imem_req ? ack_wait + 1 : 0;
      end
      if (bus.issue_valid) begin
        bus.issue_ready = (ready_wait >= ready_delay) && !(hold_en && pc == hold_pc);
        if (!bus.issue_ready) ready_wait++;
      end else begin
        bus.issue_ready = (ready_delay == 0);
        ready_wait      = 0;
      end
      bus.pc_flag = bus.issue_valid ? jump_map[pc] : 1'b1;
    end
  end

  // Monitor: compare fetch addresses on ack and issued fields on every valid cycle, pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (bus.imem_req) begin
          req_cycles++;
          if (bus.imem_ack) begin
            if (fetch_q.size() == 0) begin
              check_output("fetch_unexpected", 1, 0);
            end else begin
              check_output("fetch_addr", int'(bus.imem_addr), int'(fetch_q.pop_front()));
            end
            if (exp_req_cycles != 0) check_output("req_hold_cycles", req_cycles, exp_req_cycles);
            req_cycles = 0;
          end
        end
        if (bus.issue_valid) begin
          if (issue_q.size() == 0) begin
            check_output("issue_unexpected", 1, 0);
          end else begin
            check_output("issue_pc", int'(pc), int'(issue_q[0].pc));
            check_output("opcode", int'(bus.opcode), int'(issue_q[0].opc));
            check_output("func", int'(bus.func), int'(issue_q[0].func));
            check_output("imm", int'(bus.imm), int'(issue_q[0].imm));
            if (bus.issue_ready) begin
              void'(issue_q.pop_front());
              hs_count++;
              if (check_gap && last_hs >= 0) check_output("issue_gap", cycle - last_hs, 2);
              last_hs = cycle;
            end
          end
        end
      end
    end
  end

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (chk) begin
      check_output("rst_issue_valid", int'(bus.issue_valid), 0);
      check_output("rst_imem_req", int'(bus.imem_req), 0);
      check_output("rst_pc", int'(pc), 0);
      check_output("rst_opcode", int'(bus.opcode), 0);
      check_output("rst_func", int'(bus.func), 0);
      check_output("rst_imm", int'(bus.imm), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_cycles = 0;
  endtask

  task automatic wait_issues(input int target, input string name);
    int budget = 300;
    while (hs_count < target && budget > 0) begin
      @(negedge clk);
      #2;
      budget--;
    end
    check_output(name, int'(hs_count >= target), 1);
  endtask

  // Runs until n_stop issues, drops run (FSM is then mid-FETCH) and expects one more issue before IDLE.
  task automatic apply_stimulus(input int n_stop, input int a_delay, input int r_delay,
                                input int exp_req, input bit gap, input logic [7:0] end_pc);
    int base;
    ack_delay      = a_delay;
    ready_delay    = r_delay;
    exp_req_cycles = exp_req;
    check_gap      = gap;
    last_hs        = -1;
    base           = hs_count;
    @(negedge clk);
    run = 1'b1;
    wait_issues(base + n_stop, "run_phase_timeout");
    @(negedge clk);
    run = 1'b0;
    wait_issues(base + n_stop + 1, "drain_timeout");
    repeat (4) @(negedge clk);
    #2;
    check_output("idle_imem_req", int'(bus.imem_req), 0);
    check_output("idle_issue_valid", int'(bus.issue_valid), 0);
    check_output("idle_pc", int'(pc), int'(end_pc));
    check_output("idle_issue_count", hs_count, base + n_stop + 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got t=%0t, expected earlier finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [7:0] jt;
    clear_program();
    do_reset(1'b1);

    // Straight-line program with an opcode-9 jump at pc=3, zero-wait, back-to-back issue.
    $display("[TB] sequential fetch and jump");
`ifdef FETCH_REL_BRANCH_EN
    jt = 8'h09;
`else
    jt = 8'h05;
`endif
    clear_program();
    mem[0] = 16'h1234;
    mem[1] = 16'hF03F;
    mem[2] = 16'h4A81;
    mem[3] = 16'h9005; jump_map[3] = 1'b1;
    mem[jt] = 16'h6C07;
    mem[jt + 8'h01] = 16'hA5C3;
    exp_issue(8'h00, 4'h1, 6'h34, 8'h34);
    exp_issue(8'h01, 4'hF, 6'h3F, 8'h3F);
    exp_issue(8'h02, 4'h4, 6'h01, 8'h81);
    exp_issue(8'h03, 4'h9, 6'h05, 8'h05);
    exp_issue(jt, 4'h6, 6'h07, 8'h07);
    exp_issue(jt + 8'h01, 4'hA, 6'h03, 8'hC3);
    apply_stimulus(5, 0, 0, 0, 1'b1, jt + 8'h02);

    // Stalled memory and controller; run dropped while the second fetch is outstanding.
    $display("[TB] stalls and run drop");
    do_reset(1'b0);
    clear_program();
    mem[0] = 16'h7123;
    mem[1] = 16'h0F80;
    exp_issue(8'h00, 4'h7, 6'h23, 8'h23);
    exp_issue(8'h01, 4'h0, 6'h00, 8'h80);
    apply_stimulus(1, 3, 2, 4, 1'b0, 8'h02);

    // Jump to 0xFF, then sequential wrap to 0x00.
    $display("[TB] pc wrap");
    do_reset(1'b0);
    clear_program();
`ifdef FETCH_REL_BRANCH_EN
    mem[0] = 16'h90FE;
`else
    mem[0] = 16'h90FF;
`endif
    jump_map[0] = 1'b1;
    mem[8'hFF] = 16'h2001;
`ifdef FETCH_REL_BRANCH_EN
    exp_issue(8'h00, 4'h9, 6'h3E, 8'hFE);
    exp_issue(8'hFF, 4'h2, 6'h01, 8'h01);
    exp_issue(8'h00, 4'h9, 6'h3E, 8'hFE);
`else
    exp_issue(8'h00, 4'h9, 6'h3F, 8'hFF);
    exp_issue(8'hFF, 4'h2, 6'h01, 8'h01);
    exp_issue(8'h00, 4'h9, 6'h3F, 8'hFF);
`endif
    apply_stimulus(2, 0, 0, 0, 1'b1, 8'hFF);

    // Async reset while an instruction at pc=0x10 waits in ISSUE.
    $display("[TB] reset during issue");
    do_reset(1'b0);
    clear_program();
`ifdef FETCH_REL_BRANCH_EN
    mem[0] = 16'h900F;
    exp_issue(8'h00, 4'h9, 6'h0F, 8'h0F);
`else
    mem[0] = 16'h9010;
    exp_issue(8'h00, 4'h9, 6'h10, 8'h10);
`endif
    jump_map[0] = 1'b1;
    mem[8'h10] = 16'h3456;
    exp_issue(8'h10, 4'h3, 6'h16, 8'h56);
    ack_delay = 0; ready_delay = 0; exp_req_cycles = 0; check_gap = 1'b0;
    hold_en = 1'b1; hold_pc = 8'h10;
    base = hs_count;
    @(negedge clk);
    run = 1'b1;
    begin
      int budget = 100;
      while (!(bus.issue_valid && pc == 8'h10) && budget > 0) begin
        @(negedge clk);
        #2;
        budget--;
      end
      check_output("reach_issue_timeout", int'(budget > 0), 1);
    end
    rst_n = 1'b0;
    #1;
    check_output("async_issue_valid", int'(bus.issue_valid), 0);
    check_output("async_pc", int'(pc), 0);
    check_output("async_imem_req", int'(bus.imem_req), 0);
    check_output("async_opcode", int'(bus.opcode), 0);
    check_output("async_hs_count", hs_count, base + 1);
    check_output("async_pending", issue_q.size(), 1);
    issue_q.delete();
    hold_en = 1'b0;
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check_output("post_rst_issue_valid", int'(bus.issue_valid), 0);
    check_output("post_rst_hs_count", hs_count, base + 1);

    check_output("leftover_issues", issue_q.size(), 0);
    check_output("leftover_fetches", fetch_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
